// File: rtl/regfile_pkg.sv
// Shared constants, register address/data types and the popcount helper
// used by the register file and its scoreboard.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);
  localparam int POP_MAX   = 1024;
  localparam int POP_W     = $clog2(POP_MAX) + 1;

  typedef logic [AW_DEF-1:0]   regaddr_t;
  typedef logic [XLEN_DEF-1:0] regdata_t;

  // Callers zero-extend their pending vector to POP_MAX bits.
  function automatic logic [POP_W-1:0] popcount(input logic [POP_MAX-1:0] v);
    logic [POP_W-1:0] c;
    c = '0;
    for (int k = 0; k < POP_MAX; k++) c = c + POP_W'(v[k]);
    return c;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: set on accepted issue, cleared on writeback,
// with WAW alloc stall and a registered count of pending registers.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS  = NREGS_DEF,
  parameter int NWRITE = 1,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic [NWRITE-1:0]    wen,
  input  logic [NWRITE*AW-1:0] waddr,
  input  logic                 alloc_valid,
  input  logic [AW-1:0]        alloc_addr,
  output logic                 alloc_ready,
  output logic [NREGS-1:0]     pending,
  output logic [AW:0]          pend_cnt
);

  logic [NREGS-1:0]   pending_q, pending_d;
  logic [AW:0]        pend_cnt_q, pend_cnt_d;
  logic [NREGS-1:0]   clr;
  logic [POP_MAX-1:0] pop_in;

  always_comb begin
    clr = '0;
    for (int j = 0; j < NWRITE; j++)
      if (wen[j]) clr[waddr[j*AW +: AW]] = 1'b1;
  end

  // A writeback landing this cycle frees the register for a new producer.
  assign alloc_ready = alloc_valid &&
                       (alloc_addr == '0 || !pending_q[alloc_addr] || clr[alloc_addr]);

  always_comb begin
    pending_d = pending_q & ~clr;
    if (alloc_ready && alloc_addr != '0) pending_d[alloc_addr] = 1'b1;
    pending_d[0] = 1'b0;
    pop_in = '0;
    pop_in[NREGS-1:0] = pending_d;
    pend_cnt_d = (AW+1)'(popcount(pop_in));
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      pending_q  <= '0;
      pend_cnt_q <= '0;
    end else begin
      pending_q  <= pending_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  assign pending  = pending_q;
  assign pend_cnt = pend_cnt_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file (x0 hardwired) with integrated scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle writeback-to-read forwarding.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NREAD  = 2,
  parameter int NWRITE = 1,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic [NREAD*AW-1:0]    raddr,
  output logic [NREAD*XLEN-1:0]  rdata,
  output logic [NREAD-1:0]       rbusy,
  input  logic [NWRITE-1:0]      wen,
  input  logic [NWRITE*AW-1:0]   waddr,
  input  logic [NWRITE*XLEN-1:0] wdata,
  input  logic                   alloc_valid,
  input  logic [AW-1:0]          alloc_addr,
  output logic                   alloc_ready,
  output logic [AW:0]            pend_cnt
);

  logic [XLEN-1:0]  regs_q [1:NREGS-1];
  logic [XLEN-1:0]  regs_d [1:NREGS-1];
  logic [XLEN-1:0]  rd_view [NREGS];
  logic [NREGS-1:0] pending;

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NWRITE(NWRITE),
    .AW    (AW)
  ) u_sb (
    .clk        (clk),
    .nrst       (nrst),
    .wen        (wen),
    .waddr      (waddr),
    .alloc_valid(alloc_valid),
    .alloc_addr (alloc_addr),
    .alloc_ready(alloc_ready),
    .pending    (pending),
    .pend_cnt   (pend_cnt)
  );

  // Ascending port order lets the highest matching port win.
  always_comb begin
    for (int r = 1; r < NREGS; r++) begin
      regs_d[r] = regs_q[r];
      for (int j = 0; j < NWRITE; j++)
        if (wen[j] && waddr[j*AW +: AW] == AW'(r))
          regs_d[r] = wdata[j*XLEN +: XLEN];
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 1; r < NREGS; r++) begin
      if (!nrst) regs_q[r] <= '0;
      else       regs_q[r] <= regs_d[r];
    end
  end

  // Entry 0 reads as a constant; no storage behind it.
  always_comb begin
    rd_view[0] = '0;
    for (int r = 1; r < NREGS; r++) rd_view[r] = regs_q[r];
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;
    logic            rb;

    assign ra = raddr[i*AW +: AW];

    always_comb begin
      rd = rd_view[ra];
      rb = pending[ra];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NWRITE; j++) begin
        if (wen[j] && waddr[j*AW +: AW] == ra) begin
          rd = wdata[j*XLEN +: XLEN];
          rb = alloc_ready && alloc_addr == ra;
        end
      end
`endif
      if (ra == '0) begin
        rd = '0;
        rb = 1'b0;
      end
    end

    assign rdata[i*XLEN +: XLEN] = rd;
    assign rbusy[i]              = rb;
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed self-checking bench for regfile_mp_sb (2 read, 2 write ports).
module tb_regfile_mp_sb;
  localparam int XLEN = 32, NREGS = 32, NREAD = 2, NWRITE = 2, AW = 5;

  logic                   clk = 1'b0;
  logic                   nrst;
  logic [NREAD*AW-1:0]    raddr;
  logic [NREAD*XLEN-1:0]  rdata;
  logic [NREAD-1:0]       rbusy;
  logic [NWRITE-1:0]      wen;
  logic [NWRITE*AW-1:0]   waddr;
  logic [NWRITE*XLEN-1:0] wdata;
  logic                   alloc_valid;
  logic [AW-1:0]          alloc_addr;
  logic                   alloc_ready;
  logic [AW:0]            pend_cnt;

  int n_cmp = 0;
  int n_err = 0;

  regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .NWRITE(NWRITE)) dut (
    .clk(clk), .nrst(nrst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .wen(wen), .waddr(waddr), .wdata(wdata), .alloc_valid(alloc_valid),
    .alloc_addr(alloc_addr), .alloc_ready(alloc_ready), .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic idle();
    wen = '0; waddr = '0; wdata = '0; alloc_valid = 1'b0; alloc_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    nrst = 1'b0; idle(); raddr = '0;
    tick(); tick();
    nrst = 1'b1; raddr = {5'd5, 5'd0}; #1;
    n_cmp++; if (pend_cnt !== 6'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", pend_cnt); end
    n_cmp++; if (rdata !== 64'd0) begin n_err++; $display("FAIL reset_rdata got %h want 0", rdata); end
    // write r5 then reset again
    wen = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'd0, 32'hDEAD};
    tick(); idle(); #1;
    n_cmp++; if (rdata[63:32] !== 32'hDEAD) begin n_err++; $display("FAIL r5_write got %h want dead", rdata[63:32]); end
    alloc_valid = 1'b1; alloc_addr = 5'd5;
    nrst = 1'b0; tick(); idle(); nrst = 1'b1; #1;
    n_cmp++; if (rdata[63:32] !== 32'd0) begin n_err++; $display("FAIL r5_after_reset got %h want 0", rdata[63:32]); end
    n_cmp++; if (pend_cnt !== 6'd0) begin n_err++; $display("FAIL reset_alloc_dropped got %0d want 0", pend_cnt); end
    n_cmp++; if (rbusy !== 2'b00) begin n_err++; $display("FAIL reset_rbusy got %b want 00", rbusy); end
  endtask

  task automatic test_x0();
    raddr = {5'd0, 5'd0};
    wen = 2'b01; waddr = {5'd0, 5'd0}; wdata = {32'd0, 32'hFFFF_FFFF};
    alloc_valid = 1'b1; alloc_addr = 5'd0; #1;
    n_cmp++; if (alloc_ready !== 1'b1) begin n_err++; $display("FAIL x0_ready got %b want 1", alloc_ready); end
    n_cmp++; if (rdata[31:0] !== 32'd0 || rbusy[0] !== 1'b0) begin n_err++; $display("FAIL x0_same got %h/%b want 0/0", rdata[31:0], rbusy[0]); end
    tick(); idle(); #1;
    n_cmp++; if (rdata[31:0] !== 32'd0) begin n_err++; $display("FAIL x0_read got %h want 0", rdata[31:0]); end
    n_cmp++; if (pend_cnt !== 6'd0) begin n_err++; $display("FAIL x0_cnt got %0d want 0", pend_cnt); end
  endtask

  task automatic test_scoreboard();
    raddr = {5'd0, 5'd3};
    alloc_valid = 1'b1; alloc_addr = 5'd3; #1;
    n_cmp++; if (alloc_ready !== 1'b1) begin n_err++; $display("FAIL sb_alloc_ready got %b want 1", alloc_ready); end
    tick(); idle(); #1;
    n_cmp++; if (rbusy[0] !== 1'b1) begin n_err++; $display("FAIL sb_busy got %b want 1", rbusy[0]); end
    n_cmp++; if (pend_cnt !== 6'd1) begin n_err++; $display("FAIL sb_cnt got %0d want 1", pend_cnt); end
    alloc_valid = 1'b1; alloc_addr = 5'd3; #1;
    n_cmp++; if (alloc_ready !== 1'b0) begin n_err++; $display("FAIL sb_waw_stall got %b want 0", alloc_ready); end
    tick(); idle(); #1;
    n_cmp++; if (pend_cnt !== 6'd1) begin n_err++; $display("FAIL sb_stall_cnt got %0d want 1", pend_cnt); end
    wen = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'd0, 32'h1234};
    tick(); idle(); #1;
    n_cmp++; if (rbusy[0] !== 1'b0) begin n_err++; $display("FAIL sb_wb_busy got %b want 0", rbusy[0]); end
    n_cmp++; if (pend_cnt !== 6'd0) begin n_err++; $display("FAIL sb_wb_cnt got %0d want 0", pend_cnt); end
    n_cmp++; if (rdata[31:0] !== 32'h1234) begin n_err++; $display("FAIL sb_wb_data got %h want 1234", rdata[31:0]); end
  endtask

  task automatic test_collision();
    raddr = {5'd0, 5'd7};
    alloc_valid = 1'b1; alloc_addr = 5'd7;
    tick(); idle(); #1;
    n_cmp++; if (pend_cnt !== 6'd1) begin n_err++; $display("FAIL col_pre_cnt got %0d want 1", pend_cnt); end
    alloc_valid = 1'b1; alloc_addr = 5'd7;
    wen = 2'b10; waddr = {5'd7, 5'd0}; wdata = {32'h77, 32'd0}; #1;
    n_cmp++; if (alloc_ready !== 1'b1) begin n_err++; $display("FAIL col_ready got %b want 1", alloc_ready); end
    tick(); idle(); #1;
    n_cmp++; if (rbusy[0] !== 1'b1) begin n_err++; $display("FAIL col_pending got %b want 1", rbusy[0]); end
    n_cmp++; if (pend_cnt !== 6'd1) begin n_err++; $display("FAIL col_cnt got %0d want 1", pend_cnt); end
    n_cmp++; if (rdata[31:0] !== 32'h77) begin n_err++; $display("FAIL col_data got %h want 77", rdata[31:0]); end
    wen = 2'b01; waddr = {5'd0, 5'd7}; wdata = {32'd0, 32'h78};
    tick(); idle(); #1;
    n_cmp++; if (pend_cnt !== 6'd0) begin n_err++; $display("FAIL col_clear_cnt got %0d want 0", pend_cnt); end
  endtask

  task automatic test_dual_write();
    raddr = {5'd2, 5'd9};
    alloc_valid = 1'b1; alloc_addr = 5'd9; tick();
    alloc_addr = 5'd1; tick();
    alloc_addr = 5'd2; tick(); idle(); #1;
    n_cmp++; if (pend_cnt !== 6'd3) begin n_err++; $display("FAIL dw_cnt3 got %0d want 3", pend_cnt); end
    wen = 2'b11; waddr = {5'd9, 5'd9}; wdata = {32'hB, 32'hA};
    tick(); idle(); #1;
    n_cmp++; if (rdata[31:0] !== 32'hB) begin n_err++; $display("FAIL dw_winner got %h want b", rdata[31:0]); end
    n_cmp++; if (rbusy !== 2'b10) begin n_err++; $display("FAIL dw_busy got %b want 10", rbusy); end
    n_cmp++; if (pend_cnt !== 6'd2) begin n_err++; $display("FAIL dw_cnt2 got %0d want 2", pend_cnt); end
    wen = 2'b11; waddr = {5'd2, 5'd1}; wdata = {32'h22, 32'h11};
    tick(); idle(); #1;
    n_cmp++; if (pend_cnt !== 6'd0 || rdata[63:32] !== 32'h22) begin n_err++; $display("FAIL dw_clear got %0d/%h want 0/22", pend_cnt, rdata[63:32]); end
  endtask

  task automatic test_bypass();
    raddr = {5'd4, 5'd4};
    wen = 2'b01; waddr = {5'd0, 5'd4}; wdata = {32'd0, 32'h55}; #1;
`ifdef REGFILE_BYPASS_EN
    n_cmp++; if (rdata[31:0] !== 32'h55) begin n_err++; $display("FAIL byp_same got %h want 55", rdata[31:0]); end
`else
    n_cmp++; if (rdata[31:0] !== 32'h0) begin n_err++; $display("FAIL byp_same got %h want 0", rdata[31:0]); end
`endif
    tick(); idle(); #1;
    n_cmp++; if (rdata[31:0] !== 32'h55) begin n_err++; $display("FAIL byp_next got %h want 55", rdata[31:0]); end
    wen = 2'b11; waddr = {5'd4, 5'd4}; wdata = {32'h67, 32'h66}; #1;
`ifdef REGFILE_BYPASS_EN
    n_cmp++; if (rdata[63:32] !== 32'h67) begin n_err++; $display("FAIL byp_hi got %h want 67", rdata[63:32]); end
`else
    n_cmp++; if (rdata[63:32] !== 32'h55) begin n_err++; $display("FAIL byp_hi got %h want 55", rdata[63:32]); end
`endif
    alloc_valid = 1'b1; alloc_addr = 5'd4; #1;
`ifdef REGFILE_BYPASS_EN
    n_cmp++; if (rbusy !== 2'b11) begin n_err++; $display("FAIL byp_alloc_busy got %b want 11", rbusy); end
`else
    n_cmp++; if (rbusy !== 2'b00) begin n_err++; $display("FAIL byp_alloc_busy got %b want 00", rbusy); end
`endif
    tick(); idle(); #1;
    n_cmp++; if (rbusy !== 2'b11 || rdata[31:0] !== 32'h67) begin n_err++; $display("FAIL byp_after got %b/%h want 11/67", rbusy, rdata[31:0]); end
  endtask

  initial begin
    test_reset();
    test_x0();
    test_scoreboard();
    test_collision();
    test_dual_write();
    test_bypass();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
